// File: rtl/number_entry_pkg.sv
// ---------------------------------------------------------------------------
// number_entry_pkg
//
// Shared Bingo constants for the number-entry block: FSM state encodings,
// the blank-digit code used by the displays and the rejection reason codes.
// Also holds the helper that turns the held digits into a binary candidate.
// ---------------------------------------------------------------------------
package number_entry_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  // Digit code meaning "no digit" / blank display
  localparam logic [3:0] BLANK = 4'b1111;

  // Rejection reasons reported on err_code
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_EMPTY = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_USED  = 2'b11;

  // A keypress is usable only when it is a decimal digit.
  function automatic logic is_decimal(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Binary value of the held entry. A blank tens digit means only one digit
  // is held. Two decimal digits top out at 99, so 7 bits never overflow.
  function automatic logic [6:0] entry_value(input logic [3:0] tens,
                                             input logic [3:0] ones);
    logic [6:0] value;
    if (tens == BLANK) begin
      value = {3'b000, ones};
    end else begin
      value = ({3'b000, tens} * 7'd10) + {3'b000, ones};
    end
    return value;
  endfunction

endpackage

// File: rtl/number_entry.sv
// ---------------------------------------------------------------------------
// number_entry
//
// Collects up to two decimal digits from the keyboard stage, and on a confirm
// evaluates them as a Bingo number. A valid, not-yet-called number is
// committed to num_out and recorded in used_mask; anything else is rejected
// with a reason code.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   digit_in     decimal digit 0..9 (4'b1111 = no digit)
//   digit_valid  one-cycle keypress strobe qualifying digit_in
//   enter_pulse  one-cycle confirm
//   clear_pulse  one-cycle discard of the pending digits
//   new_game     clears pending digits and the used-number record
//   num_out      last committed number (binary)
//   num_valid    one-cycle pulse when num_out is updated
//   err_pulse    one-cycle pulse on a rejected confirm
//   err_code     reason of the last rejection (01 empty, 10 range, 11 used)
//   disp_tens    pending tens digit for the display (4'b1111 = blank)
//   disp_ones    pending ones digit for the display (4'b1111 = blank)
//   used_mask    bit k-1 set once number k has been called
// ---------------------------------------------------------------------------
module number_entry
  import number_entry_pkg::*;
#(
  parameter int MAX_NUM = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         digit_in,
  input  logic               digit_valid,
  input  logic               enter_pulse,
  input  logic               clear_pulse,
  input  logic               new_game,
  output logic [6:0]         num_out,
  output logic               num_valid,
  output logic               err_pulse,
  output logic [1:0]         err_code,
  output logic [3:0]         disp_tens,
  output logic [3:0]         disp_ones,
  output logic [MAX_NUM-1:0] used_mask
);

  logic [1:0]         state, state_nxt;
  logic [3:0]         d_tens, d_tens_nxt;
  logic [3:0]         d_ones, d_ones_nxt;
  logic [6:0]         num_out_nxt;
  logic               num_valid_nxt;
  logic               err_pulse_nxt;
  logic [1:0]         err_code_nxt;
  logic [MAX_NUM-1:0] used_mask_nxt;

  logic [6:0]         candidate;
  logic [MAX_NUM-1:0] cand_onehot;
  logic               cand_in_range;
  logic               cand_used;

  // Evaluate the held digits as a number. The one-hot decode is built by
  // comparison rather than by indexing used_mask with the 7-bit value, so a
  // value outside 1..MAX_NUM simply decodes to all zeros and can never
  // address a bit that does not exist.
  always_comb begin
    candidate     = entry_value(d_tens, d_ones);
    cand_in_range = (candidate != 7'd0) && (candidate <= 7'(MAX_NUM));
    cand_onehot   = '0;
    for (int k = 0; k < MAX_NUM; k++) begin
      cand_onehot[k] = (candidate == 7'(k + 1));
    end
    cand_used = |(used_mask & cand_onehot);
  end

  // Next-state logic. The if/else chain encodes the event priority:
  // new_game first, then the CHECK evaluation (which ignores keys, clear and
  // enter), then clear, then enter, then a digit. Anything lower in the chain
  // is dropped when a higher event fires in the same cycle.
  always_comb begin
    state_nxt     = state;
    d_tens_nxt    = d_tens;
    d_ones_nxt    = d_ones;
    num_out_nxt   = num_out;
    num_valid_nxt = 1'b0;
    err_pulse_nxt = 1'b0;
    err_code_nxt  = err_code;
    used_mask_nxt = used_mask;

    if (new_game) begin
      // Fresh game: forget pending digits and every called number, but keep
      // the last number on num_out and emit no pulses.
      state_nxt     = ST_IDLE;
      d_tens_nxt    = BLANK;
      d_ones_nxt    = BLANK;
      used_mask_nxt = '0;
    end else if (state == ST_CHECK) begin
      // One-cycle evaluation of the digits captured when enter was seen.
      // Either way the entry is consumed and the displays go blank.
      state_nxt  = ST_IDLE;
      d_tens_nxt = BLANK;
      d_ones_nxt = BLANK;
      if (!cand_in_range) begin
        err_pulse_nxt = 1'b1;
        err_code_nxt  = ERR_RANGE;
      end else if (cand_used) begin
        err_pulse_nxt = 1'b1;
        err_code_nxt  = ERR_USED;
      end else begin
        num_out_nxt   = candidate;
        num_valid_nxt = 1'b1;
        used_mask_nxt = used_mask | cand_onehot;
      end
    end else if (clear_pulse) begin
      state_nxt  = ST_IDLE;
      d_tens_nxt = BLANK;
      d_ones_nxt = BLANK;
    end else if (enter_pulse) begin
      // Confirm with nothing typed is rejected straight away; otherwise the
      // digits are frozen for the evaluation cycle.
      if (state == ST_IDLE) begin
        err_pulse_nxt = 1'b1;
        err_code_nxt  = ERR_EMPTY;
      end else begin
        state_nxt = ST_CHECK;
      end
    end else if (digit_valid && is_decimal(digit_in)) begin
      // Digits shift in from the right; with two already held the oldest
      // one falls off so the operator can just keep typing to correct.
      case (state)
        ST_IDLE: begin
          state_nxt  = ST_ONE;
          d_tens_nxt = BLANK;
          d_ones_nxt = digit_in;
        end
        ST_ONE, ST_TWO: begin
          state_nxt  = ST_TWO;
          d_tens_nxt = d_ones;
          d_ones_nxt = digit_in;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // State and output registers. Reset discards any pending or in-flight
  // entry, so nothing can be committed out of a CHECK cycle cut short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      d_tens    <= BLANK;
      d_ones    <= BLANK;
      num_out   <= 7'd0;
      num_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
      used_mask <= '0;
    end else begin
      state     <= state_nxt;
      d_tens    <= d_tens_nxt;
      d_ones    <= d_ones_nxt;
      num_out   <= num_out_nxt;
      num_valid <= num_valid_nxt;
      err_pulse <= err_pulse_nxt;
      err_code  <= err_code_nxt;
      used_mask <= used_mask_nxt;
    end
  end

  // Display copies of the held digits, one register stage behind them so
  // the display path is isolated from the FSM logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_tens <= BLANK;
      disp_ones <= BLANK;
    end else begin
      disp_tens <= d_tens;
      disp_ones <= d_ones;
    end
  end

endmodule

// File: tb/tb_number_entry.sv
// ---------------------------------------------------------------------------
// tb_number_entry
//
// Self-checking bench for number_entry. Directed scenarios check the
// documented key sequences against literal expected values; a randomized run
// compares every output each cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_number_entry;

  localparam int MAX = 25;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     digit_in;
  logic           digit_valid;
  logic           enter_pulse;
  logic           clear_pulse;
  logic           new_game;
  logic [6:0]     num_out;
  logic           num_valid;
  logic           err_pulse;
  logic [1:0]     err_code;
  logic [3:0]     disp_tens;
  logic [3:0]     disp_ones;
  logic [MAX-1:0] used_mask;

  int errors = 0;
  int checks = 0;

  number_entry #(.MAX_NUM(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .enter_pulse (enter_pulse),
    .clear_pulse (clear_pulse),
    .new_game    (new_game),
    .num_out     (num_out),
    .num_valid   (num_valid),
    .err_pulse   (err_pulse),
    .err_code    (err_code),
    .disp_tens   (disp_tens),
    .disp_ones   (disp_ones),
    .used_mask   (used_mask)
  );

  always #5 clk = ~clk;

  // Reference model: pending digits as a queue, called numbers as a set.
  int q[$];
  bit checking;
  bit used[1:99];
  int m_num, m_code, m_dt, m_do;
  bit m_valid, m_err;

  function automatic void model_reset();
    q.delete();
    checking = 0;
    foreach (used[i]) used[i] = 0;
    m_num = 0; m_code = 0; m_valid = 0; m_err = 0; m_dt = 15; m_do = 15;
  endfunction

  function automatic void model_step(bit ng, bit clr, bit ent, bit dv, int dig);
    int v;
    m_dt = (q.size() == 2) ? q[0] : 15;
    m_do = (q.size() >= 1) ? q[q.size()-1] : 15;
    m_valid = 0;
    m_err = 0;
    if (ng) begin
      q.delete();
      checking = 0;
      foreach (used[i]) used[i] = 0;
    end else if (checking) begin
      v = (q.size() == 2) ? q[0] * 10 + q[1] : q[0];
      checking = 0;
      q.delete();
      if (v < 1 || v > MAX) begin
        m_err = 1; m_code = 2;
      end else if (used[v]) begin
        m_err = 1; m_code = 3;
      end else begin
        used[v] = 1; m_num = v; m_valid = 1;
      end
    end else if (clr) begin
      q.delete();
    end else if (ent) begin
      if (q.size() == 0) begin
        m_err = 1; m_code = 1;
      end else begin
        checking = 1;
      end
    end else if (dv && dig <= 9) begin
      q.push_back(dig);
      if (q.size() > 2) void'(q.pop_front());
    end
  endfunction

  function automatic logic [MAX-1:0] model_mask();
    logic [MAX-1:0] m;
    m = '0;
    for (int k = 1; k <= MAX; k++) if (used[k]) m[k-1] = 1'b1;
    return m;
  endfunction

  // Drives one cycle of inputs from a negedge, lets the DUT clock them in,
  // steps the model and returns at the following negedge for sampling.
  task automatic drive_cycle(input bit ng, input bit clr, input bit ent,
                             input bit dv, input logic [3:0] dig);
    new_game    = ng;
    clear_pulse = clr;
    enter_pulse = ent;
    digit_valid = dv;
    digit_in    = dig;
    @(posedge clk);
    model_step(ng, clr, ent, dv, int'(dig));
    @(negedge clk);
    new_game    = 1'b0;
    clear_pulse = 1'b0;
    enter_pulse = 1'b0;
    digit_valid = 1'b0;
    digit_in    = 4'hF;
  endtask

  task automatic press(input int d);
    drive_cycle(0, 0, 0, 1, 4'(d));
  endtask

  task automatic enter();
    drive_cycle(0, 0, 1, 0, 4'hF);
  endtask

  task automatic idle();
    drive_cycle(0, 0, 0, 0, 4'hF);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (num_out !== 7'd0) begin errors++; $display("[TB] FAIL reset_num_out: got %0d expected 0", num_out); end
    checks++; if (num_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_num_valid: got %b expected 0", num_valid); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_pulse: got %b expected 0", err_pulse); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("[TB] FAIL reset_err_code: got %b expected 00", err_code); end
    checks++; if (disp_tens !== 4'hF || disp_ones !== 4'hF) begin errors++; $display("[TB] FAIL reset_disp: got %h/%h expected f/f", disp_tens, disp_ones); end
    checks++; if (used_mask !== '0) begin errors++; $display("[TB] FAIL reset_used_mask: got %h expected 0", used_mask); end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_commit_17();
    press(1); press(7); enter();
    checks++; if (num_valid !== 1'b0) begin errors++; $display("[TB] FAIL c17_check_cycle: num_valid got %b expected 0", num_valid); end
    idle();
    checks++; if (num_valid !== 1'b1) begin errors++; $display("[TB] FAIL c17_valid: got %b expected 1", num_valid); end
    checks++; if (num_out !== 7'd17) begin errors++; $display("[TB] FAIL c17_num_out: got %0d expected 17", num_out); end
    checks++; if (used_mask[16] !== 1'b1) begin errors++; $display("[TB] FAIL c17_used_bit: got %b expected 1", used_mask[16]); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL c17_err: got %b expected 0", err_pulse); end
    idle();
    checks++; if (num_valid !== 1'b0) begin errors++; $display("[TB] FAIL c17_pulse_width: got %b expected 0", num_valid); end
  endtask

  task automatic test_repeat_17();
    press(1); press(7); enter(); idle();
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("[TB] FAIL r17_err: got %b expected 1", err_pulse); end
    checks++; if (err_code !== 2'b11) begin errors++; $display("[TB] FAIL r17_code: got %b expected 11", err_code); end
    checks++; if (num_out !== 7'd17) begin errors++; $display("[TB] FAIL r17_num_out: got %0d expected 17", num_out); end
    checks++; if (num_valid !== 1'b0) begin errors++; $display("[TB] FAIL r17_valid: got %b expected 0", num_valid); end
  endtask

  task automatic test_range();
    press(2); press(6); enter(); idle();
    checks++; if (err_pulse !== 1'b1 || err_code !== 2'b10) begin errors++; $display("[TB] FAIL range_26: got err=%b code=%b expected 1/10", err_pulse, err_code); end
    press(0); enter(); idle();
    checks++; if (err_pulse !== 1'b1 || err_code !== 2'b10) begin errors++; $display("[TB] FAIL range_0: got err=%b code=%b expected 1/10", err_pulse, err_code); end
    enter();
    checks++; if (err_pulse !== 1'b1 || err_code !== 2'b01) begin errors++; $display("[TB] FAIL empty_enter: got err=%b code=%b expected 1/01", err_pulse, err_code); end
    checks++; if (num_out !== 7'd17) begin errors++; $display("[TB] FAIL range_num_out: got %0d expected 17", num_out); end
  endtask

  task automatic test_shift();
    press(3); idle();
    checks++; if (disp_tens !== 4'hF || disp_ones !== 4'd3) begin errors++; $display("[TB] FAIL shift_one_digit: got %h/%h expected f/3", disp_tens, disp_ones); end
    press(1); press(5); idle();
    checks++; if (disp_tens !== 4'd1 || disp_ones !== 4'd5) begin errors++; $display("[TB] FAIL shift_disp: got %h/%h expected 1/5", disp_tens, disp_ones); end
    enter(); idle();
    checks++; if (num_valid !== 1'b1 || num_out !== 7'd15) begin errors++; $display("[TB] FAIL shift_commit: got valid=%b num=%0d expected 1/15", num_valid, num_out); end
  endtask

  task automatic test_priority();
    press(4);
    drive_cycle(0, 1, 1, 1, 4'd2);
    checks++; if (err_pulse !== 1'b0 || num_valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_pulse0: got err=%b valid=%b expected 0/0", err_pulse, num_valid); end
    idle();
    checks++; if (err_pulse !== 1'b0 || num_valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_pulse1: got err=%b valid=%b expected 0/0", err_pulse, num_valid); end
    checks++; if (disp_tens !== 4'hF || disp_ones !== 4'hF) begin errors++; $display("[TB] FAIL prio_disp: got %h/%h expected f/f", disp_tens, disp_ones); end
    checks++; if (num_out !== 7'd15) begin errors++; $display("[TB] FAIL prio_num_out: got %0d expected 15", num_out); end
  endtask

  task automatic test_new_game();
    press(5); enter(); idle();
    checks++; if (num_valid !== 1'b1 || num_out !== 7'd5) begin errors++; $display("[TB] FAIL ng_first5: got valid=%b num=%0d expected 1/5", num_valid, num_out); end
    drive_cycle(1, 0, 0, 0, 4'hF);
    checks++; if (used_mask !== '0) begin errors++; $display("[TB] FAIL ng_mask: got %h expected 0", used_mask); end
    checks++; if (num_out !== 7'd5 || num_valid !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL ng_hold: got num=%0d valid=%b err=%b expected 5/0/0", num_out, num_valid, err_pulse); end
    press(5); enter(); idle();
    checks++; if (num_valid !== 1'b1 || num_out !== 7'd5) begin errors++; $display("[TB] FAIL ng_second5: got valid=%b num=%0d expected 1/5", num_valid, num_out); end
  endtask

  task automatic test_full_card();
    drive_cycle(1, 0, 0, 0, 4'hF);
    for (int v = 1; v <= MAX; v++) begin
      if (v >= 10) press(v / 10);
      press(v % 10);
      enter(); idle();
      checks++; if (num_valid !== 1'b1 || num_out !== 7'(v)) begin errors++; $display("[TB] FAIL full_commit_%0d: got valid=%b num=%0d expected 1/%0d", v, num_valid, num_out, v); end
    end
    checks++; if (used_mask !== {MAX{1'b1}}) begin errors++; $display("[TB] FAIL full_mask: got %h expected all ones", used_mask); end
    press(1); press(3); enter(); idle();
    checks++; if (err_pulse !== 1'b1 || err_code !== 2'b11) begin errors++; $display("[TB] FAIL full_13: got err=%b code=%b expected 1/11", err_pulse, err_code); end
    press(3); press(0); enter(); idle();
    checks++; if (err_pulse !== 1'b1 || err_code !== 2'b10) begin errors++; $display("[TB] FAIL full_30: got err=%b code=%b expected 1/10", err_pulse, err_code); end
    checks++; if (num_out !== 7'(MAX)) begin errors++; $display("[TB] FAIL full_num_hold: got %0d expected %0d", num_out, MAX); end
  endtask

  task automatic test_reset_in_check();
    drive_cycle(1, 0, 0, 0, 4'hF);
    press(2); enter();
    rst = 1'b0;
    #2;
    checks++; if (num_out !== 7'd0 || used_mask !== '0) begin errors++; $display("[TB] FAIL rstchk_async: got num=%0d mask=%h expected 0/0", num_out, used_mask); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (num_valid !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL rstchk_pulse: got valid=%b err=%b expected 0/0", num_valid, err_pulse); end
    rst = 1'b1;
    model_reset();
    idle();
    checks++; if (num_valid !== 1'b0 || used_mask !== '0) begin errors++; $display("[TB] FAIL rstchk_after: got valid=%b mask=%h expected 0/0", num_valid, used_mask); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      bit ng, clr, ent, dv;
      logic [3:0] dig;
      ng  = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 19) == 0);
      ent = ($urandom_range(0, 4) == 0);
      dv  = ($urandom_range(0, 1) == 1);
      dig = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      drive_cycle(ng, clr, ent, dv, dig);
      checks++; if (num_out !== 7'(m_num)) begin errors++; $display("[TB] FAIL rnd_num_out@%0d: got %0d expected %0d", n, num_out, m_num); end
      checks++; if (num_valid !== m_valid || err_pulse !== m_err) begin errors++; $display("[TB] FAIL rnd_pulses@%0d: got valid=%b err=%b expected %b/%b", n, num_valid, err_pulse, m_valid, m_err); end
      checks++; if (err_code !== 2'(m_code)) begin errors++; $display("[TB] FAIL rnd_err_code@%0d: got %0d expected %0d", n, err_code, m_code); end
      checks++; if (disp_tens !== 4'(m_dt) || disp_ones !== 4'(m_do)) begin errors++; $display("[TB] FAIL rnd_disp@%0d: got %h/%h expected %h/%h", n, disp_tens, disp_ones, m_dt, m_do); end
      checks++; if (used_mask !== model_mask()) begin errors++; $display("[TB] FAIL rnd_mask@%0d: got %h expected %h", n, used_mask, model_mask()); end
      checks++; if (num_valid === 1'b1 && err_pulse === 1'b1) begin errors++; $display("[TB] FAIL rnd_exclusive@%0d: got both pulses high expected at most one", n); end
    end
  endtask

  initial begin
    rst         = 1'b1;
    digit_in    = 4'hF;
    digit_valid = 1'b0;
    enter_pulse = 1'b0;
    clear_pulse = 1'b0;
    new_game    = 1'b0;
    model_reset();
    test_reset();
    test_commit_17();
    test_repeat_17();
    test_range();
    test_shift();
    test_priority();
    test_new_game();
    test_full_card();
    test_reset_in_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
